// File: rtl/unpack_tag_wrr.sv
// Deficit-weighted round-robin merge of four per-channel packet tags into one
// registered tag stream; credit is counted in 64-byte blocks.
module unpack_tag_wrr #(
    parameter int WEIGHT0 = 16,
    parameter int WEIGHT1 = 16,
    parameter int WEIGHT2 = 8,
    parameter int WEIGHT3 = 8
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iPktTagVld0,
    input  logic        iPktTagVld1,
    input  logic        iPktTagVld2,
    input  logic        iPktTagVld3,
    input  logic [11:0] iPktFirAddr0,
    input  logic [11:0] iPktFirAddr1,
    input  logic [11:0] iPktFirAddr2,
    input  logic [11:0] iPktFirAddr3,
    input  logic [3:0]  iPktLen0,
    input  logic [3:0]  iPktLen1,
    input  logic [3:0]  iPktLen2,
    input  logic [3:0]  iPktLen3,
    input  logic [2:0]  iPktPri0,
    input  logic [2:0]  iPktPri1,
    input  logic [2:0]  iPktPri2,
    input  logic [2:0]  iPktPri3,
    input  logic [3:0]  iPktDstPort0,
    input  logic [3:0]  iPktDstPort1,
    input  logic [3:0]  iPktDstPort2,
    input  logic [3:0]  iPktDstPort3,
    output logic        oWrrRdy0,
    output logic        oWrrRdy1,
    output logic        oWrrRdy2,
    output logic        oWrrRdy3,
    output logic        oTagVld,
    output logic [11:0] oTagFirAddr,
    output logic [3:0]  oTagLen,
    output logic [2:0]  oTagPri,
    output logic [3:0]  oTagDstPort,
    output logic [1:0]  oTagSrcPort,
    input  logic        iTagRdy
);
    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [7:0] WEIGHTS [4] = '{8'(WEIGHT0), 8'(WEIGHT1), 8'(WEIGHT2), 8'(WEIGHT3)};

    state_t      state;
    logic [1:0]  rPtr;
    logic [7:0]  rCredit;

    logic [3:0]  pktVld;
    logic [11:0] pktAddr [4];
    logic [3:0]  pktLen  [4];
    logic [2:0]  pktPri  [4];
    logic [3:0]  pktDst  [4];
    logic [4:0]  cost    [4];
    logic [7:0]  reload  [4];

    logic        load;
    logic        serveHit;
    logic        switchHit;
    logic [1:0]  switchIdx;
    logic [1:0]  cand;
    logic        grant;
    logic [1:0]  grantIdx;

    assign pktVld     = {iPktTagVld3, iPktTagVld2, iPktTagVld1, iPktTagVld0};
    assign pktAddr[0] = iPktFirAddr0;
    assign pktAddr[1] = iPktFirAddr1;
    assign pktAddr[2] = iPktFirAddr2;
    assign pktAddr[3] = iPktFirAddr3;
    assign pktLen[0]  = iPktLen0;
    assign pktLen[1]  = iPktLen1;
    assign pktLen[2]  = iPktLen2;
    assign pktLen[3]  = iPktLen3;
    assign pktPri[0]  = iPktPri0;
    assign pktPri[1]  = iPktPri1;
    assign pktPri[2]  = iPktPri2;
    assign pktPri[3]  = iPktPri3;
    assign pktDst[0]  = iPktDstPort0;
    assign pktDst[1]  = iPktDstPort1;
    assign pktDst[2]  = iPktDstPort2;
    assign pktDst[3]  = iPktDstPort3;

    // A switched-to channel always gets one packet; leftover credit saturates at zero.
    for (genvar gi = 0; gi < 4; gi++) begin : gCost
        assign cost[gi]   = {1'b0, pktLen[gi]} + 5'd1;
        assign reload[gi] = (WEIGHTS[gi] > {3'b000, cost[gi]}) ? (WEIGHTS[gi] - {3'b000, cost[gi]}) : 8'd0;
    end

    always_comb begin
        load      = !oTagVld || iTagRdy;
        serveHit  = (state == SERVE) && pktVld[rPtr] && (rCredit >= {3'b000, cost[rPtr]});
        switchHit = 1'b0;
        switchIdx = rPtr;
        cand      = rPtr;
        // Descending scan so the nearest channel after rPtr wins; k=4 wraps to rPtr itself.
        for (int k = 4; k >= 1; k--) begin
            cand = rPtr + 2'(k);
            if (pktVld[cand]) begin
                switchHit = 1'b1;
                switchIdx = cand;
            end
        end
        grant    = load && (serveHit || switchHit);
        grantIdx = serveHit ? rPtr : switchIdx;
    end

    assign oWrrRdy0 = iRst_n && grant && (grantIdx == 2'd0);
    assign oWrrRdy1 = iRst_n && grant && (grantIdx == 2'd1);
    assign oWrrRdy2 = iRst_n && grant && (grantIdx == 2'd2);
    assign oWrrRdy3 = iRst_n && grant && (grantIdx == 2'd3);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            rPtr        <= 2'd3;
            rCredit     <= 8'd0;
            oTagVld     <= 1'b0;
            oTagFirAddr <= '0;
            oTagLen     <= '0;
            oTagPri     <= '0;
            oTagDstPort <= '0;
            oTagSrcPort <= '0;
        end else if (load) begin
            oTagVld <= grant;
            if (grant) begin
                oTagFirAddr <= pktAddr[grantIdx];
                oTagLen     <= pktLen[grantIdx];
                oTagPri     <= pktPri[grantIdx];
                oTagDstPort <= pktDst[grantIdx];
                oTagSrcPort <= grantIdx;
            end
            if (serveHit) begin
                rCredit <= rCredit - {3'b000, cost[rPtr]};
            end else if (switchHit) begin
                state   <= SERVE;
                rPtr    <= switchIdx;
                rCredit <= reload[switchIdx];
            end else begin
                state   <= IDLE;
                rCredit <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_unpack_tag_wrr.sv
// Bench for unpack_tag_wrr: directed scenarios with literal grant/credit
// sequences, then random traffic, all checked every cycle against a queue-level model.
module tb_unpack_tag_wrr;
    localparam int W [4] = '{16, 16, 8, 8};

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        tVld  [4];
    logic [11:0] tAddr [4];
    logic [3:0]  tLen  [4];
    logic [2:0]  tPri  [4];
    logic [3:0]  tDst  [4];
    logic        tagRdy = 1'b1;

    logic        oWrrRdy0, oWrrRdy1, oWrrRdy2, oWrrRdy3;
    logic        oTagVld;
    logic [11:0] oTagFirAddr;
    logic [3:0]  oTagLen;
    logic [2:0]  oTagPri;
    logic [3:0]  oTagDstPort;
    logic [1:0]  oTagSrcPort;

    int checks = 0;
    int errors = 0;

    // Model state: which channel owns the turn, its remaining credit, the expected output register.
    int          mPtr = 3;
    int          mCredit = 0;
    bit          mServe = 0;
    bit          eVld = 0;
    logic [24:0] eData = '0;
    int          mGrant = -1;

    bit keep [4];
    int fixLen [4];
    int arrivePct = 100;
    bit logEn = 0;
    int gLog [$];
    int cLog [$];
    int expQ [$];

    always #5 clk = ~clk;

    unpack_tag_wrr #(.WEIGHT0(16), .WEIGHT1(16), .WEIGHT2(8), .WEIGHT3(8)) dut (
        .iClk(clk), .iRst_n(rstN),
        .iPktTagVld0(tVld[0]), .iPktTagVld1(tVld[1]), .iPktTagVld2(tVld[2]), .iPktTagVld3(tVld[3]),
        .iPktFirAddr0(tAddr[0]), .iPktFirAddr1(tAddr[1]), .iPktFirAddr2(tAddr[2]), .iPktFirAddr3(tAddr[3]),
        .iPktLen0(tLen[0]), .iPktLen1(tLen[1]), .iPktLen2(tLen[2]), .iPktLen3(tLen[3]),
        .iPktPri0(tPri[0]), .iPktPri1(tPri[1]), .iPktPri2(tPri[2]), .iPktPri3(tPri[3]),
        .iPktDstPort0(tDst[0]), .iPktDstPort1(tDst[1]), .iPktDstPort2(tDst[2]), .iPktDstPort3(tDst[3]),
        .oWrrRdy0(oWrrRdy0), .oWrrRdy1(oWrrRdy1), .oWrrRdy2(oWrrRdy2), .oWrrRdy3(oWrrRdy3),
        .oTagVld(oTagVld), .oTagFirAddr(oTagFirAddr), .oTagLen(oTagLen), .oTagPri(oTagPri),
        .oTagDstPort(oTagDstPort), .oTagSrcPort(oTagSrcPort), .iTagRdy(tagRdy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: check outputs, then advance the model by one clock.
    always @(negedge clk) begin : cmp
        int g;
        int cst;
        int s;
        int dutIdx;
        logic [3:0] dutRdy;
        logic [3:0] expRdy;
        dutRdy = {oWrrRdy3, oWrrRdy2, oWrrRdy1, oWrrRdy0};
        dutIdx = -1;
        for (int i = 3; i >= 0; i--) if (dutRdy[i]) dutIdx = i;
        if (!rstN) begin
            mPtr = 3; mCredit = 0; mServe = 0; eVld = 0; eData = '0; mGrant = -1;
            check("reset_vld", 64'(oTagVld), 64'd0);
            check("reset_rdy", 64'(dutRdy), 64'd0);
            check("reset_data", 64'({oTagFirAddr, oTagLen, oTagPri, oTagDstPort, oTagSrcPort}), 64'd0);
        end else begin
            check("tag_vld", 64'(oTagVld), 64'(eVld));
            if (eVld)
                check("tag_data", 64'({oTagFirAddr, oTagLen, oTagPri, oTagDstPort, oTagSrcPort}), 64'(eData));
            g = -1;
            if (!eVld || tagRdy) begin
                cst = (mServe && tVld[mPtr]) ? int'(tLen[mPtr]) + 1 : 0;
                if (mServe && tVld[mPtr] && mCredit >= cst) begin
                    g = mPtr;
                    mCredit = mCredit - cst;
                end else begin
                    for (int k = 1; k <= 4 && g < 0; k++) begin
                        s = (mPtr + k) % 4;
                        if (tVld[s]) g = s;
                    end
                    if (g >= 0) begin
                        mPtr = g;
                        mServe = 1;
                        cst = int'(tLen[g]) + 1;
                        mCredit = (W[g] > cst) ? W[g] - cst : 0;
                    end else begin
                        mServe = 0;
                        mCredit = 0;
                    end
                end
                eVld = (g >= 0);
                if (g >= 0) eData = {tAddr[g], tLen[g], tPri[g], tDst[g], 2'(g)};
            end
            expRdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            check("grant", 64'(dutRdy), 64'(expRdy));
            mGrant = g;
            if (logEn) begin
                gLog.push_back(dutIdx);
                cLog.push_back(mCredit);
            end
        end
    end

    task automatic newTag(input int c);
        tVld[c]  = 1'b1;
        tAddr[c] = 12'($urandom);
        tLen[c]  = (fixLen[c] < 0) ? 4'($urandom_range(15)) : 4'(fixLen[c]);
        tPri[c]  = 3'($urandom);
        tDst[c]  = 4'($urandom);
    endtask

    // Retire the tag granted last cycle, then refill channels that keep feeding.
    task automatic beginCycle();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) if (mGrant == c) tVld[c] = 1'b0;
        for (int c = 0; c < 4; c++)
            if (keep[c] && !tVld[c] && $urandom_range(99) < arrivePct) newTag(c);
    endtask

    task automatic drain();
        for (int c = 0; c < 4; c++) keep[c] = 0;
        tagRdy = 1'b1;
        repeat (3) begin
            beginCycle();
            for (int c = 0; c < 4; c++) tVld[c] = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic startLog();
        gLog.delete();
        cLog.delete();
        logEn = 1;
    endtask

    task automatic checkLog(input string name, input bit useCredit);
        int act;
        for (int i = 0; i < expQ.size(); i++) begin
            if (useCredit) act = (i < cLog.size()) ? cLog[i] : -2;
            else           act = (i < gLog.size()) ? gLog[i] : -2;
            check($sformatf("%s[%0d]", name, i), 64'(act), 64'(expQ[i]));
        end
        logEn = 0;
    endtask

    initial begin : stim
        logic [11:0] addrA;
        logic [11:0] addrB;
        for (int c = 0; c < 4; c++) begin
            tVld[c] = 0; tAddr[c] = 0; tLen[c] = 0; tPri[c] = 0; tDst[c] = 0;
            keep[c] = 0; fixLen[c] = -1;
        end
        repeat (3) @(negedge clk);
        check("por_vld", 64'(oTagVld), 64'd0);
        @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        #1;

        // All channels busy with 16-block packets: plain rotation, one per cycle.
        for (int c = 0; c < 4; c++) begin keep[c] = 1; fixLen[c] = 15; end
        startLog();
        repeat (8) beginCycle();
        @(negedge clk);
        #1;
        check("p1_len", 64'(oTagLen), 64'd15);
        expQ = '{0, 1, 2, 3, 0, 1, 2, 3};
        checkLog("p1_order", 0);
        $display("phase1 rotation done, checks=%0d errors=%0d", checks, errors);
        drain();

        // Channel 0 alone, 4-block packets, exactly ten tags.
        keep[0] = 1; fixLen[0] = 3;
        startLog();
        for (int i = 0; i < 12; i++) begin
            if (i == 10) keep[0] = 0;
            beginCycle();
        end
        @(negedge clk);
        #1;
        expQ = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1};
        checkLog("p2_grant", 0);
        expQ = '{12, 8, 4, 0, 12, 8, 4, 0, 12, 8, 0, 0};
        checkLog("p2_credit", 1);
        $display("phase2 single channel done, checks=%0d errors=%0d", checks, errors);
        drain();

        // Channels 0/1 share turns of four; channel 2 (long packets) joins and gets one per turn.
        keep[0] = 1; fixLen[0] = 3; keep[1] = 1; fixLen[1] = 3; fixLen[2] = 15;
        startLog();
        for (int i = 0; i < 22; i++) begin
            if (i == 12) keep[2] = 1;
            beginCycle();
        end
        @(negedge clk);
        #1;
        expQ = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 1, 1, 1, 1, 2};
        checkLog("p3_order", 0);
        $display("phase3 weighted sharing done, checks=%0d errors=%0d", checks, errors);
        drain();

        // Backpressure: output held for five cycles while channel 1 waits.
        keep[1] = 1; fixLen[1] = 2;
        startLog();
        beginCycle();
        addrA = tAddr[1];
        addrB = '0;
        for (int i = 0; i < 5; i++) begin
            beginCycle();
            if (i == 0) addrB = tAddr[1];
            tagRdy = 1'b0;
            @(negedge clk);
            #1;
            check("p4_hold_addr", 64'(oTagFirAddr), 64'(addrA));
            check("p4_hold_src", 64'(oTagSrcPort), 64'd1);
        end
        beginCycle();
        tagRdy = 1'b1;
        keep[1] = 0;
        beginCycle();
        @(negedge clk);
        #1;
        check("p4_new_addr", 64'(oTagFirAddr), 64'(addrB));
        expQ = '{1, -1, -1, -1, -1, -1, 1, -1};
        checkLog("p4_grant", 0);
        $display("phase4 backpressure done, checks=%0d errors=%0d", checks, errors);
        drain();

        // Channel 2 leaves mid-turn, channel 3 takes over at once, channel 2 returns with a fresh reload.
        keep[2] = 1; fixLen[2] = 0; fixLen[3] = 0;
        startLog();
        repeat (3) beginCycle();
        keep[2] = 0;
        beginCycle();
        tVld[2] = 1'b0;
        keep[3] = 1;
        newTag(3);
        repeat (2) beginCycle();
        keep[3] = 0;
        beginCycle();
        tVld[3] = 1'b0;
        keep[2] = 1;
        newTag(2);
        @(negedge clk);
        #1;
        expQ = '{2, 2, 2, 3, 3, 3, 2};
        checkLog("p5_grant", 0);
        expQ = '{7, 6, 5, 7, 6, 5, 7};
        checkLog("p5_credit", 1);
        $display("phase5 mid-turn switch done, checks=%0d errors=%0d", checks, errors);
        drain();

        // Asynchronous reset with a tag in flight; arbitration restarts at channel 0.
        for (int c = 0; c < 4; c++) begin keep[c] = 1; fixLen[c] = -1; end
        repeat (4) beginCycle();
        #1 check("p6_pre_vld", 64'(oTagVld), 64'd1);
        #1 rstN = 1'b0;
        #1;
        check("p6_rst_vld", 64'(oTagVld), 64'd0);
        check("p6_rst_rdy", 64'({oWrrRdy3, oWrrRdy2, oWrrRdy1, oWrrRdy0}), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        startLog();
        beginCycle();
        rstN = 1'b1;
        @(negedge clk);
        #1;
        expQ = '{0};
        checkLog("p6_first", 0);
        $display("phase6 async reset done, checks=%0d errors=%0d", checks, errors);

        // Random arrivals, lengths and backpressure.
        arrivePct = 30;
        repeat (3000) begin
            beginCycle();
            tagRdy = ($urandom_range(9) < 7);
        end
        @(negedge clk);
        #1;
        $display("phase7 random traffic done, checks=%0d errors=%0d", checks, errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
